// File: rtl/tap_pkg.sv
// Shared types for the tagged-word decoder: FSM state encoding and the
// width of one stored FIFO entry ({epoch, raw timestamp, payload}).
package tap_pkg;

   typedef enum logic {
      WAIT_PING = 1'b0,
      RUN       = 1'b1
   } tap_state_e;

   // A stored entry is the payload plus the full extended timestamp.
   function automatic int entry_w(input int data_w, input int time_w);
      return data_w + time_w;
   endfunction

endpackage

// File: rtl/tap_fifo.sv
// Show-ahead FIFO for decoded words. The head entry is read combinationally
// from storage, so a word written at one edge is presented right after it.
// A push into a full FIFO is accepted only when a pop happens the same cycle.
module tap_fifo #(
   parameter int DEPTH   = 8,
   parameter int ENTRY_W = 48
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               push,
   input  logic [ENTRY_W-1:0] push_data,
   input  logic               pop,
   output logic               full,
   output logic               empty,
   output logic [ENTRY_W-1:0] head
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH + 1);
   localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

   logic [ENTRY_W-1:0] mem [DEPTH];
   logic [AW-1:0]      wr_ptr;
   logic [AW-1:0]      rd_ptr;
   logic [CW-1:0]      count;
   logic               do_push;
   logic               do_pop;

   assign empty   = (count == '0);
   assign full    = (count == FULL_CNT);
   assign do_pop  = pop && !empty;
   assign do_push = push && (!full || do_pop);
   assign head    = mem[rd_ptr];

   // Pointer and occupancy bookkeeping; pointers wrap naturally (DEPTH is 2^n).
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + AW'(1);
         if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
         case ({do_push, do_pop})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;
         endcase
      end
   end

   // Entry storage; cleared on reset so the presented head reads as zero.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      end else if (do_push) begin
         mem[wr_ptr] <= push_data;
      end
   end

endmodule

// File: rtl/tap_decode.sv
// Tagged-word decoder: extends the raw timestamp of each word with an epoch
// counter that restarts on every global ping and advances whenever the raw
// timestamp steps backwards. Decoded words are queued in a show-ahead FIFO.
module tap_decode
   import tap_pkg::*;
#(
   parameter int WIDTH_1     = 32,
   parameter int WIDTH_2     = 16,
   parameter int TIMER_WIDTH = 8,
   parameter int DEPTH       = 8
) (
   input  logic                           clk,
   input  logic                           rst_n,
   input  logic                           global_ping,
   input  logic                           in_valid,
   input  logic [WIDTH_1+TIMER_WIDTH-1:0] in_data,
   output logic                           out_valid,
   input  logic                           out_ready,
   output logic [WIDTH_1-1:0]             out_data,
   output logic [WIDTH_2-1:0]             out_time,
   output logic                           overflow,
   output logic                           epoch_err
);

   localparam int EPOCH_W = WIDTH_2 - TIMER_WIDTH;
   localparam int ENTRY_W = entry_w(WIDTH_1, WIDTH_2);

   tap_state_e             state;
   tap_state_e             state_nxt;
   logic                   ping_q;
   logic                   ping_ev;
   logic [EPOCH_W-1:0]     epoch_q;
   logic [EPOCH_W-1:0]     epoch_base;
   logic [EPOCH_W-1:0]     epoch_nxt;
   logic                   first_q;
   logic                   first_eff;
   logic                   first_nxt;
   logic [TIMER_WIDTH-1:0] last_raw_q;
   logic [TIMER_WIDTH-1:0] raw;
   logic [WIDTH_1-1:0]     payload;
   logic                   proc;
   logic                   inc;
   logic                   wrap;
   logic                   fifo_full;
   logic                   fifo_empty;
   logic                   pop;
   logic [ENTRY_W-1:0]     head;

   assign raw     = in_data[WIDTH_1+TIMER_WIDTH-1 -: TIMER_WIDTH];
   assign payload = in_data[WIDTH_1-1:0];
   assign pop     = out_valid && out_ready;

   // Next state and epoch decode; a ping in the same cycle as a word is applied first.
   always_comb begin
      state_nxt  = state;
      proc       = 1'b0;
      ping_ev    = (global_ping != ping_q);
      case (state)
         WAIT_PING: begin
            if (ping_ev) state_nxt = RUN;
            proc = in_valid && ping_ev;
         end
         RUN:     proc = in_valid;
         default: state_nxt = WAIT_PING;
      endcase
      first_eff  = ping_ev || first_q;
      epoch_base = ping_ev ? '0 : epoch_q;
      inc        = proc && !first_eff && (raw < last_raw_q);
      wrap       = inc && (&epoch_base);
      epoch_nxt  = inc ? epoch_base + EPOCH_W'(1) : epoch_base;
      first_nxt  = proc ? 1'b0 : first_eff;
   end

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= WAIT_PING;
      else        state <= state_nxt;
   end

   // Ping edge memory, epoch tracking and sticky error flags.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ping_q     <= 1'b0;
         epoch_q    <= '0;
         first_q    <= 1'b0;
         last_raw_q <= '0;
         overflow   <= 1'b0;
         epoch_err  <= 1'b0;
      end else begin
         ping_q  <= global_ping;
         epoch_q <= epoch_nxt;
         first_q <= first_nxt;
         // Tracked even for dropped words so wrap detection survives overflow.
         if (proc) last_raw_q <= raw;
         if (proc && fifo_full && !pop) overflow <= 1'b1;
         if (wrap) epoch_err <= 1'b1;
      end
   end

   tap_fifo #(
      .DEPTH   (DEPTH),
      .ENTRY_W (ENTRY_W)
   ) u_fifo (
      .clk       (clk),
      .rst_n     (rst_n),
      .push      (proc),
      .push_data ({epoch_nxt, raw, payload}),
      .pop       (pop),
      .full      (fifo_full),
      .empty     (fifo_empty),
      .head      (head)
   );

   assign out_valid = !fifo_empty;
   assign out_time  = head[WIDTH_1 +: WIDTH_2];
   assign out_data  = head[WIDTH_1-1:0];

endmodule

// File: tb/tb_tap_decode.sv
// Bench for tap_decode: directed word sequences, expected outputs queued at
// issue time and checked by an independent monitor as the DUT drains them.
module tb_tap_decode;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        global_ping = 1'b0;
   logic        in_valid = 1'b0;
   logic [39:0] in_data = '0;
   logic        out_valid;
   logic        out_ready = 1'b0;
   logic [31:0] out_data;
   logic [15:0] out_time;
   logic        overflow;
   logic        epoch_err;

   int n_tests = 0;
   int n_fail  = 0;
   logic [47:0] exp_q [$];

   tap_decode dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .global_ping (global_ping),
      .in_valid    (in_valid),
      .in_data     (in_data),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .out_data    (out_data),
      .out_time    (out_time),
      .overflow    (overflow),
      .epoch_err   (epoch_err)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [47:0] act, input logic [47:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Monitor: every accepted head is compared against the oldest expectation.
   always @(negedge clk) begin
      if (rst_n && out_valid && out_ready) begin
         if (exp_q.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL unexpected_out: got time %0h data %0h expected nothing", out_time, out_data);
         end else begin
            logic [47:0] e;
            e = exp_q.pop_front();
            check("out_word", {out_time, out_data}, e);
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send(input logic [7:0] raw, input logic [31:0] pay,
                       input bit expect_out, input logic [15:0] t);
      in_valid = 1'b1;
      in_data  = {raw, pay};
      if (expect_out) exp_q.push_back({t, pay});
      tick();
      in_valid = 1'b0;
   endtask

   task automatic ping_alone();
      global_ping = ~global_ping;
      tick();
   endtask

   task automatic drain(input string name);
      int cyc;
      cyc = 0;
      while ((exp_q.size() != 0 || out_valid) && cyc < 300) begin
         tick();
         cyc++;
      end
      check(name, 48'(exp_q.size()), 48'd0);
   endtask

   initial begin
      // Reset state
      tick();
      check("rst_out_valid", 48'(out_valid), 48'd0);
      check("rst_overflow", 48'(overflow), 48'd0);
      check("rst_epoch_err", 48'(epoch_err), 48'd0);
      check("rst_out_time", 48'(out_time), 48'd0);
      rst_n = 1'b1;
      tick();

      // Words before the first ping are discarded
      out_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         send(8'h05, 32'h50 + 32'(i), 1'b0, 16'h0);
         check("preping_valid", 48'(out_valid), 48'd0);
      end
      check("preping_ovf", 48'(overflow), 48'd0);
      check("preping_err", 48'(epoch_err), 48'd0);

      // First ping, then FE, FF, 01 across a raw wrap
      ping_alone();
      check("empty_before", 48'(out_valid), 48'd0);
      send(8'hFE, 32'hA, 1'b1, 16'h00FE);
      check("latency_one", 48'(out_valid), 48'd1);
      send(8'hFF, 32'hB, 1'b1, 16'h00FF);
      send(8'h01, 32'hC, 1'b1, 16'h0101);
      // Advance to epoch 3, then ping coincident with a word
      send(8'h00, 32'hD, 1'b1, 16'h0200);
      send(8'hF0, 32'hE, 1'b1, 16'h02F0);
      send(8'h00, 32'hF, 1'b1, 16'h0300);
      send(8'h00, 32'h11, 1'b1, 16'h0300);
      global_ping = ~global_ping;
      send(8'h10, 32'h12, 1'b1, 16'h0010);
      send(8'h08, 32'h13, 1'b1, 16'h0108);
      drain("drain_basic");

      // Fill to DEPTH with no consumer, ninth word dropped
      ping_alone();
      out_ready = 1'b0;
      for (int i = 0; i < 8; i++)
         send(8'h20 + 8'(i), 32'h100 + 32'(i), 1'b1, 16'h0020 + 16'(i));
      check("full_no_ovf", 48'(overflow), 48'd0);
      send(8'h28, 32'h108, 1'b0, 16'h0);
      check("full_ovf", 48'(overflow), 48'd1);
      check("full_valid", 48'(out_valid), 48'd1);
      out_ready = 1'b1;
      send(8'h30, 32'h109, 1'b1, 16'h0030);
      drain("drain_full");

      // 256 wraps within one epoch
      ping_alone();
      send(8'h10, 32'h4000, 1'b1, 16'h0010);
      for (int k = 1; k <= 256; k++) begin
         logic [7:0] e;
         e = 8'(k);
         if (k == 256) check("err_before_wrap", 48'(epoch_err), 48'd0);
         send(8'h00, 32'h5000 + 32'(k), 1'b1, {e, 8'h00});
         send(8'h10, 32'h6000 + 32'(k), 1'b1, {e, 8'h10});
      end
      check("err_after_wrap", 48'(epoch_err), 48'd1);
      drain("drain_wrap");

      // Reset with words queued
      out_ready = 1'b0;
      for (int i = 0; i < 4; i++) send(8'h40 + 8'(i), 32'h700 + 32'(i), 1'b0, 16'h0);
      check("pre_rst_valid", 48'(out_valid), 48'd1);
      #2;
      rst_n = 1'b0;
      #1;
      check("async_rst_valid", 48'(out_valid), 48'd0);
      check("async_rst_ovf", 48'(overflow), 48'd0);
      check("async_rst_err", 48'(epoch_err), 48'd0);
      exp_q.delete();
      tick();
      rst_n = 1'b1;
      out_ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         send(8'h50, 32'h800 + 32'(i), 1'b0, 16'h0);
         check("post_rst_wait", 48'(out_valid), 48'd0);
      end
      global_ping = ~global_ping;
      send(8'h77, 32'h900, 1'b1, 16'h0077);
      drain("drain_post_rst");

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/tap_decode.md
TAP_DECODE -- requirements
Module: tap_decode

Interface
REQ-001 SHALL have parameter WIDTH_1, default 32: payload data width.
REQ-002 SHALL have parameter WIDTH_2, default 16: extended timestamp width; epoch width = WIDTH_2-TIMER_WIDTH.
REQ-003 SHALL have parameter TIMER_WIDTH, default 8: raw timestamp width in tagged word.
REQ-004 SHALL have parameter DEPTH, default 8, power of two: output FIFO depth.
REQ-005 SHALL have port clk  input  1  single clock; all logic rising-edge.
REQ-006 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-007 SHALL have port global_ping  input  1  synchronous epoch marker; every level change is one ping event.
REQ-008 SHALL have port in_valid  input  1  tagged word present.
REQ-009 SHALL have port in_data  input  WIDTH_1+TIMER_WIDTH  tagged word: [top TIMER_WIDTH bits] raw timestamp, [WIDTH_1-1:0] payload.
REQ-010 SHALL have port out_valid  output  1  FIFO head valid.
REQ-011 SHALL have port out_ready  input  1  consumer accepts head.
REQ-012 SHALL have port out_data  output  WIDTH_1  head payload.
REQ-013 SHALL have port out_time  output  WIDTH_2  head extended timestamp {epoch, raw}.
REQ-014 SHALL have port overflow  output  1  sticky: word dropped on full FIFO.
REQ-015 SHALL have port epoch_err  output  1  sticky: epoch counter wrapped.

Function
REQ-016 SHALL register global_ping into ping_q; ping event = (global_ping != ping_q).
REQ-017 SHALL have two states: WAIT_PING (after reset) and RUN; WAIT_PING->RUN on first ping event; no other transition except reset.
REQ-018 SHALL, in WAIT_PING, discard all in_valid words without touching FIFO or flags.
REQ-019 SHALL, on each ping event, set epoch to 0 and mark next word "first of epoch".
REQ-020 SHALL, in RUN with in_valid, increment epoch when raw < last_raw and word not first of epoch; equal raw SHALL NOT increment.
REQ-021 SHALL, on epoch increment from all-ones, wrap to 0 and set epoch_err.
REQ-022 SHALL, when ping event and in_valid coincide, apply ping first: word tagged epoch 0, becomes first of epoch; also valid for the WAIT_PING->RUN cycle.
REQ-023 SHALL update last_raw on every accepted-or-dropped RUN word, so wrap tracking continues through overflow.
REQ-024 SHALL push {epoch_after_update, raw, payload} into FIFO when RUN, in_valid and FIFO not full.
REQ-025 SHALL, when FIFO full and in_valid in RUN with no pop that cycle, drop the word and set overflow.
REQ-026 SHALL allow push and pop in same cycle, including when full (no drop) or empty with push (no bypass).
REQ-027 SHALL present head show-ahead: word pushed at edge N visible with out_valid=1 after edge N (one-cycle latency).
REQ-028 SHALL pop on out_valid && out_ready; out_data/out_time SHALL hold stable while out_valid && !out_ready.
REQ-029 SHALL hold out_data/out_time at last value when empty (don't-care for checks).

Reset
REQ-030 SHALL, on rst_n low, asynchronously clear: state=WAIT_PING, ping_q=0, epoch=0, last_raw=0, FIFO pointers/count=0, out_valid=0, out_data=0, out_time=0, overflow=0, epoch_err=0.
REQ-031 SHALL, on reset mid-operation, discard FIFO contents; first ping after release required before any output.
REQ-032 SHALL clear sticky flags only by reset.

Structure
REQ-033 SHALL place state enum (WAIT_PING, RUN) and FIFO entry struct width helper in shared package tap_pkg.
REQ-034 SHALL implement storage in one sub-module tap_fifo (DEPTH, entry width parameters; push/pop/full/empty, show-ahead).
REQ-035 SHALL keep decode logic (ping detect, FSM, epoch tracking) in tap_decode top.

Verification
REQ-036 Words before first ping: in_valid=1, raw 0x05 -> out_valid stays 0, no flags.
REQ-037 Ping toggle 0->1 then raws 0xFE, 0xFF, 0x01, payloads 0xA,0xB,0xC -> out_time 0x00FE, 0x00FF, 0x0101 in order, one-cycle latency, out_ready=1.
REQ-038 Ping coincident with in_valid raw 0x10 after epoch 3 -> out_time 0x0010; next raw 0x08 -> 0x0108.
REQ-039 out_ready=0, push 9 words with DEPTH=8 -> 8 retained in order, 9th dropped, overflow=1; simultaneous push/pop when full -> no drop.
REQ-040 256 consecutive raw wraps in one epoch -> epoch returns to 0, epoch_err=1.
REQ-041 rst_n low for 1 cycle with 4 words queued -> out_valid=0 immediately, flags 0, state WAIT_PING.
